instr_fetch_buffer: RTL and testbench

- Prefetch stage directly upstream of the single-cycle CPU datapath.
- Generates sequential fetch addresses and issues them to an instruction memory over a req/ack handshake.
- Buffers returned words, each with its PC, in a small FIFO.
- Delivers instructions to decode over valid/ready; a branch/jump redirect flushes the queue and restarts fetch at the target.

---
 rtl/instr_fetch_buffer.sv | 198 +++++++++++++++++++
 tb/tb_instr_fetch_buffer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_buffer.sv
// Sequential instruction prefetcher feeding decode through a small PC-tagged FIFO.
// Optional IFB_BYPASS_EN forwards an acked word straight to decode while the FIFO is empty.
module instr_fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_pc_i,
  output logic                   mem_req_o,
  output logic [31:0]            mem_addr_o,
  input  logic                   mem_ack_i,
  input  logic [31:0]            mem_data_i,
  output logic                   instr_valid_o,
  output logic [31:0]            instr_o,
  output logic [31:0]            instr_pc_o,
  input  logic                   instr_ready_i,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [31:0]   STEP_C  = 32'(PC_STEP);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_DROP = 2'd2} state_t;

  state_t        state_r, state_s;
  logic [31:0]   fetch_pc_r, fetch_pc_s;
  logic [31:0]   req_addr_r, req_addr_s;
  logic [31:0]   data_mem_r [DEPTH];
  logic [31:0]   pc_mem_r   [DEPTH];
  logic [AW-1:0] rd_ptr_r, rd_ptr_s, wr_ptr_r, wr_ptr_s;
  logic [CW-1:0] count_r, count_s, remain_s;
  logic          valid_r, valid_s;
  logic [31:0]   instr_r, instr_s, instr_pc_r, instr_pc_s;
  logic          ack_push_s, push_s, pop_s, bypass_take_s;

  // Handshake qualifiers; a redirect cancels both the push and the pop of its cycle
  always_comb begin
    ack_push_s = (state_r == ST_WAIT) && mem_ack_i && !redirect_i;
    pop_s      = valid_r && instr_ready_i && !redirect_i;
  end

`ifdef IFB_BYPASS_EN
  logic bypass_vld_s;
  assign bypass_vld_s  = ack_push_s && (count_r == {CW{1'b0}});
  assign bypass_take_s = bypass_vld_s && instr_ready_i;
  assign instr_valid_o = valid_r || bypass_vld_s;
  assign instr_o       = bypass_vld_s ? mem_data_i : instr_r;
  assign instr_pc_o    = bypass_vld_s ? fetch_pc_r : instr_pc_r;
`else
  assign bypass_take_s = 1'b0;
  assign instr_valid_o = valid_r;
  assign instr_o       = instr_r;
  assign instr_pc_o    = instr_pc_r;
`endif

  assign push_s     = ack_push_s && !bypass_take_s;
  assign mem_req_o  = (state_r != ST_IDLE);
  assign mem_addr_o = req_addr_r;
  assign count_o    = count_r;

  // Fetch FSM next state, request address and fetch PC
  always_comb begin
    state_s    = state_r;
    req_addr_s = req_addr_r;
    fetch_pc_s = fetch_pc_r;
    case (state_r)
      ST_IDLE: begin
        if (!redirect_i && (count_r < DEPTH_C)) begin
          state_s    = ST_WAIT;
          req_addr_s = fetch_pc_r;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (mem_ack_i) begin
          state_s = ST_IDLE;
        end else if (redirect_i) begin
          state_s = ST_DROP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DROP: begin
        if (mem_ack_i) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DROP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
    if (redirect_i) begin
      fetch_pc_s = redirect_pc_i & 32'hFFFF_FFFC;
    end else if (ack_push_s) begin
      fetch_pc_s = fetch_pc_r + STEP_C;
    end else begin
      fetch_pc_s = fetch_pc_r;
    end
  end

  // FIFO pointers, occupancy and the registered head entry
  always_comb begin
    rd_ptr_s   = rd_ptr_r;
    wr_ptr_s   = wr_ptr_r;
    count_s    = count_r;
    instr_s    = instr_r;
    instr_pc_s = instr_pc_r;
    if (redirect_i) begin
      rd_ptr_s = {AW{1'b0}};
      wr_ptr_s = {AW{1'b0}};
      count_s  = {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_s = wr_ptr_r + AW'(1);
      else        wr_ptr_s = wr_ptr_r;
      if (pop_s) rd_ptr_s = rd_ptr_r + AW'(1);
      else       rd_ptr_s = rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_s = count_r + CW'(1);
        2'b01:   count_s = count_r - CW'(1);
        default: count_s = count_r;
      endcase
    end
    remain_s = pop_s ? (count_r - CW'(1)) : count_r;
    valid_s  = (count_s != {CW{1'b0}});
    // The new head is either already stored or is the word being pushed into an emptied FIFO
    if (!valid_s) begin
      instr_s    = instr_r;
      instr_pc_s = instr_pc_r;
    end else if (remain_s == {CW{1'b0}}) begin
      instr_s    = mem_data_i;
      instr_pc_s = fetch_pc_r;
    end else begin
      instr_s    = data_mem_r[rd_ptr_s];
      instr_pc_s = pc_mem_r[rd_ptr_s];
    end
  end

  // State, storage and output registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r    <= ST_IDLE;
      fetch_pc_r <= RESET_PC;
      req_addr_r <= RESET_PC;
      rd_ptr_r   <= {AW{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      valid_r    <= 1'b0;
      instr_r    <= 32'h0000_0000;
      instr_pc_r <= 32'h0000_0000;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_mem_r[i] <= 32'h0000_0000;
        pc_mem_r[i]   <= 32'h0000_0000;
      end
    end else begin
      state_r    <= state_s;
      fetch_pc_r <= fetch_pc_s;
      req_addr_r <= req_addr_s;
      rd_ptr_r   <= rd_ptr_s;
      wr_ptr_r   <= wr_ptr_s;
      count_r    <= count_s;
      valid_r    <= valid_s;
      instr_r    <= instr_s;
      instr_pc_r <= instr_pc_s;
      if (push_s) begin
        data_mem_r[wr_ptr_r] <= mem_data_i;
        pc_mem_r[wr_ptr_r]   <= fetch_pc_r;
      end
    end
  end

  instr_fetch_buffer_chk #(.DEPTH(DEPTH)) u_chk (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_s),
    .count_i (count_r)
  );
endmodule

// Simulation-only protocol checks for instr_fetch_buffer.
module instr_fetch_buffer_chk #(
  parameter int unsigned DEPTH = 4
) (
  input logic                   clk_i,
  input logic                   rst_i,
  input logic                   push_i,
  input logic [$clog2(DEPTH):0] count_i
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Room accounting must never let a word arrive for a full FIFO
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_i) !(push_i && (count_i == DEPTH_C)));
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed self-checking bench for instr_fetch_buffer (DEPTH=4, RESET_PC=0, PC_STEP=4).
module tb_instr_fetch_buffer;
  localparam logic [31:0] K = 32'h5A5A_0000;

  logic        clk_i = 1'b0;
  logic        rst_i, redirect_i, mem_ack_i, instr_ready_i;
  logic [31:0] redirect_pc_i, mem_data_i;
  logic        mem_req_o, instr_valid_o;
  logic [31:0] mem_addr_o, instr_o, instr_pc_o;
  logic [2:0]  count_o;
  logic [31:0] hold_addr;
  logic [31:0] exp_pc;
  logic        seen_req;
  int          checks = 0;
  int          errors = 0;
  int          na, np, pops;

  instr_fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_data_i    (mem_data_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i),
    .count_o       (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; memory acks any visible request at once unless its address is held
  task automatic cyc();
    @(posedge clk_i);
    @(negedge clk_i);
    mem_ack_i  = mem_req_o && (mem_addr_o != hold_addr);
    mem_data_i = mem_addr_o ^ K;
  endtask

  task automatic do_reset();
    rst_i      = 1'b0;
    redirect_i = 1'b0;
    mem_ack_i  = 1'b0;
    mem_data_i = 32'h0;
    hold_addr  = 32'hFFFF_FFFF;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    rst_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; mem_ack_i = 1'b0;
    mem_data_i = 32'h0; instr_ready_i = 1'b1; hold_addr = 32'hFFFF_FFFF;
    @(negedge clk_i);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_pc", instr_pc_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Free run with ready held high
    na = 0; np = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (mem_req_o && na < 4) begin
        chk("free_addr", mem_addr_o, 32'(na * 4));
        na++;
      end
      if (instr_valid_o && np < 3) begin
        chk("free_pc", instr_pc_o, 32'(np * 4));
        chk("free_instr", instr_o, 32'(np * 4) ^ K);
        np++;
      end
      chk("free_count_le1", 32'(count_o <= 3'd1), 32'd1);
    end
    chk("free_nreq", 32'(na), 32'd4);
    chk("free_npop", 32'(np), 32'd3);

    // Backpressure: exactly four requests fill the FIFO
    instr_ready_i = 1'b0;
    do_reset();
    na = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (mem_req_o) na++;
    end
    chk("bp_nreq", 32'(na), 32'd4);
    chk("bp_req_idle", 32'(mem_req_o), 32'd0);
    chk("bp_count", 32'(count_o), 32'd4);
    chk("bp_head_pc", instr_pc_o, 32'd0);
    instr_ready_i = 1'b1;
    exp_pc = 32'd0; pops = 0; seen_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (instr_valid_o) begin
        chk("drain_pc", instr_pc_o, exp_pc);
        chk("drain_instr", instr_o, exp_pc ^ K);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (mem_req_o && !seen_req) begin
        chk("resume_addr", mem_addr_o, 32'h10);
        seen_req = 1'b1;
      end
      if (pops == 6) break;
      cyc();
    end
    chk("drain_npop", 32'(pops), 32'd6);
    chk("drain_resumed", 32'(seen_req), 32'd1);

    // Redirect while the addr-8 request is pending; ack arrives later and is dropped
    do_reset();
    hold_addr = 32'h8;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (mem_req_o && mem_addr_o == 32'h8) break;
    end
    chk("rw_pend_addr", mem_addr_o, 32'h8);
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    cyc();
    redirect_i = 1'b0;
    chk("rw_drop_req", 32'(mem_req_o), 32'd1);
    chk("rw_drop_addr", mem_addr_o, 32'h8);
    chk("rw_drop_count", 32'(count_o), 32'd0);
    chk("rw_drop_valid", 32'(instr_valid_o), 32'd0);
    cyc();
    chk("rw_drop_addr2", mem_addr_o, 32'h8);
    mem_ack_i = 1'b1; mem_data_i = 32'hDEAD_BEEF;
    cyc();
    chk("rw_after_req", 32'(mem_req_o), 32'd0);
    chk("rw_after_valid", 32'(instr_valid_o), 32'd0);
    chk("rw_after_count", 32'(count_o), 32'd0);
    hold_addr = 32'hFFFF_FFFF;
    cyc();
    chk("rw_new_addr", mem_addr_o, 32'h100);
    cyc();
    chk("rw_new_valid", 32'(instr_valid_o), 32'd1);
    chk("rw_new_pc", instr_pc_o, 32'h100);
    chk("rw_new_instr", instr_o, 32'h100 ^ K);

    // Redirect with simultaneous ack and pop, two entries queued
    instr_ready_i = 1'b0;
    do_reset();
    hold_addr = 32'h8;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (mem_req_o && mem_addr_o == 32'h8) break;
    end
    chk("rap_count2", 32'(count_o), 32'd2);
    redirect_i = 1'b1; redirect_pc_i = 32'h103;
    mem_ack_i = 1'b1; mem_data_i = 32'hCAFE_0008; instr_ready_i = 1'b1;
    cyc();
    redirect_i = 1'b0;
    hold_addr  = 32'hFFFF_FFFF;
    chk("rap_count0", 32'(count_o), 32'd0);
    chk("rap_valid0", 32'(instr_valid_o), 32'd0);
    chk("rap_req0", 32'(mem_req_o), 32'd0);
    cyc();
    chk("rap_addr", mem_addr_o, 32'h100);
    cyc();
    chk("rap_pc", instr_pc_o, 32'h100);
    chk("rap_instr", instr_o, 32'h100 ^ K);

    // Asynchronous reset while a request is outstanding
    instr_ready_i = 1'b0;
    do_reset();
    hold_addr = 32'h4;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (mem_req_o && mem_addr_o == 32'h4) break;
    end
    chk("ar_pre_count", 32'(count_o), 32'd1);
    #2 rst_i = 1'b0;
    #1;
    chk("ar_req", 32'(mem_req_o), 32'd0);
    chk("ar_valid", 32'(instr_valid_o), 32'd0);
    chk("ar_count", 32'(count_o), 32'd0);
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1; hold_addr = 32'hFFFF_FFFF;
    cyc();
    chk("ar_first_req", 32'(mem_req_o), 32'd1);
    chk("ar_first_addr", mem_addr_o, 32'h0);

    // Empty-FIFO ack timing (bypass or one-cycle latency)
    instr_ready_i = 1'b1;
    do_reset();
    hold_addr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (mem_req_o) break;
    end
    mem_ack_i = 1'b1; mem_data_i = 32'h2402_000A;
    #1;
`ifdef IFB_BYPASS_EN
    chk("bp0_valid", 32'(instr_valid_o), 32'd1);
    chk("bp0_instr", instr_o, 32'h2402_000A);
    chk("bp0_pc", instr_pc_o, 32'h0);
`else
    chk("bp0_valid", 32'(instr_valid_o), 32'd0);
`endif
    chk("bp0_count", 32'(count_o), 32'd0);
    cyc();
`ifdef IFB_BYPASS_EN
    chk("bp1_valid", 32'(instr_valid_o), 32'd0);
    chk("bp1_count", 32'(count_o), 32'd0);
`else
    chk("bp1_valid", 32'(instr_valid_o), 32'd1);
    chk("bp1_instr", instr_o, 32'h2402_000A);
    chk("bp1_pc", instr_pc_o, 32'h0);
    chk("bp1_count", 32'(count_o), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
